rib_arbiter: RTL and testbench

// Round-robin arbiter sharing the single RIB memory/peripheral slave port between three masters:
// m0 = core load/store port, m1 = debug/JTAG, m2 = DMA. Sits between those masters and the RIB slave decode.

---
 rtl/rib_arbiter.sv | 156 +++++++++++++++
 tb/tb_rib_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rib_arbiter.sv
// Round-robin arbiter sharing one RIB slave port between core (m0), debug (m1) and DMA (m2).
// One transaction in flight at a time, with a per-transaction timeout that aborts hung slaves.
module rib_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          m_req_i,
    input  logic [2:0]          m_we_i,
    input  logic [3*ADDR_W-1:0] m_addr_i,
    input  logic [3*DATA_W-1:0] m_wdata_i,
    output logic [DATA_W-1:0]   m_rdata_o,
    output logic [2:0]          m_ack_o,
    output logic [2:0]          m_err_o,
    output logic [2:0]          grant_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic [DATA_W-1:0]   s_rdata_i,
    input  logic                s_ack_i,
    output logic                hold_flag_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [2:0]          ack_q, ack_d;
    logic [2:0]          err_q, err_d;
    logic                s_req_q, s_req_d;
    logic                s_we_q, s_we_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          last_q, last_d;

    logic [ADDR_W-1:0]   addr_a  [3];
    logic [DATA_W-1:0]   wdata_a [3];
    logic [2:0]          eligible;
    logic [1:0]          ord0, ord1, ord2;
    logic [1:0]          win;

    for (genvar i = 0; i < 3; i++) begin : g_unpack
        assign addr_a[i]  = m_addr_i[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = m_wdata_i[i*DATA_W +: DATA_W];
    end

    // A master whose completion pulse is out this cycle is dropping its request; keep it out.
    assign eligible = m_req_i & ~(ack_q | err_q);

    always_comb begin
        ord0 = 2'd0;
        ord1 = 2'd1;
        ord2 = 2'd2;
        case (last_q)
            2'd0: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
            2'd1: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
            default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
        endcase
        win = ord2;
        if (eligible[ord0])      win = ord0;
        else if (eligible[ord1]) win = ord1;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ack_d     = 3'b000;
        err_d     = 3'b000;
        s_req_d   = s_req_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (eligible != 3'b000) begin
                    state_d   = BUSY;
                    grant_d   = 3'b001 << win;
                    s_req_d   = 1'b1;
                    s_we_d    = m_we_i[win];
                    s_addr_d  = addr_a[win];
                    s_wdata_d = wdata_a[win];
                    cnt_d     = '0;
                    last_d    = win;
                end
            end
            BUSY: begin
                // An ack arriving on the final allowed cycle beats the timeout.
                if (s_ack_i) begin
                    state_d = IDLE;
                    grant_d = 3'b000;
                    s_req_d = 1'b0;
                    ack_d   = grant_q;
                    rdata_d = s_rdata_i;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    grant_d = 3'b000;
                    s_req_d = 1'b0;
                    err_d   = grant_q;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 3'b000;
            ack_q     <= 3'b000;
            err_q     <= 3'b000;
            s_req_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            last_q    <= 2'd2;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            s_req_q   <= s_req_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign m_rdata_o   = rdata_q;
    assign m_ack_o     = ack_q;
    assign m_err_o     = err_q;
    assign grant_o     = grant_q;
    assign s_req_o     = s_req_q;
    assign s_we_o      = s_we_q;
    assign s_addr_o    = s_addr_q;
    assign s_wdata_o   = s_wdata_q;
    assign hold_flag_o = m_req_i[0] & ~ack_q[0] & ~err_q[0];

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: reset, single read, round-robin order, timeout,
// last-cycle ack, request dropped mid-transaction, reset mid-transaction.
module tb_rib_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  m_req;
    logic [2:0]  m_we;
    logic [31:0] a0, a1, a2;
    logic [31:0] w0, w1, w2;
    logic [95:0] m_addr;
    logic [95:0] m_wdata;
    logic [31:0] m_rdata;
    logic [2:0]  m_ack, m_err, grant;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_ack;
    logic        hold_flag;

    int vectors = 0;
    int miscompares = 0;

    assign m_addr  = {a2, a1, a0};
    assign m_wdata = {w2, w1, w0};

    rib_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_rdata_o(m_rdata), .m_ack_o(m_ack), .m_err_o(m_err), .grant_o(grant),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_rdata_i(s_rdata), .s_ack_i(s_ack), .hold_flag_o(hold_flag)
    );

    always #5 clk = ~clk;

    // Inputs are changed and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expects an active grant this cycle; slave acks with data, then checks the pulse.
    task automatic serve(input string tag, input logic [2:0] exp_g, input logic [31:0] exp_a,
                         input logic [31:0] data);
        chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
        chk({tag, "_saddr"}, s_addr, exp_a);
        s_ack   = 1'b1;
        s_rdata = data;
        step();
        chk({tag, "_ack"}, 32'(m_ack), 32'(exp_g));
        chk({tag, "_rdata"}, m_rdata, data);
        chk({tag, "_sreq_off"}, 32'(s_req), 32'd0);
        s_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; m_req = 3'b000; m_we = 3'b000;
        a0 = '0; a1 = '0; a2 = '0; w0 = '0; w1 = '0; w2 = '0;
        s_rdata = '0; s_ack = 1'b0;
        step(); step();

        // Reset state
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sreq", 32'(s_req), 32'd0);
        chk("rst_ack_err", 32'({m_ack, m_err}), 32'd0);
        chk("rst_saddr", s_addr, 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_hold", 32'(hold_flag), 32'd0);

        // Round robin with all three requesting and a 1-cycle slave
        rst_n = 1'b1;
        m_req = 3'b111; a0 = 32'h100; a1 = 32'h200; a2 = 32'h300;
        step();
        serve("rr0", 3'b001, 32'h100, 32'h11);
        step();
        serve("rr1", 3'b010, 32'h200, 32'h22);
        step();
        serve("rr2", 3'b100, 32'h300, 32'h33);
        step();
        serve("rr3", 3'b001, 32'h100, 32'h44);
        m_req = 3'b000;
        step();
        chk("rr_idle", 32'(grant), 32'd0);

        // Single read from m0, ack on first BUSY cycle
        m_req = 3'b001; a0 = 32'h1000;
        #1;
        chk("rd_hold_n", 32'(hold_flag), 32'd1);
        step();
        chk("rd_hold_n1", 32'(hold_flag), 32'd1);
        chk("rd_swe", 32'(s_we), 32'd0);
        serve("rd", 3'b001, 32'h1000, 32'hDEADBEEF);
        chk("rd_hold_n2", 32'(hold_flag), 32'd0);
        m_req = 3'b000;
        step();
        chk("rd_ack_clr", 32'(m_ack), 32'd0);

        // Slave ack while idle is ignored
        s_ack = 1'b1; s_rdata = 32'h99;
        step();
        chk("idle_ack_ign", 32'(m_ack), 32'd0);
        chk("idle_rdata_keep", m_rdata, 32'hDEADBEEF);
        s_ack = 1'b0;

        // Timeout: m2 write, slave never answers
        m_req = 3'b100; m_we = 3'b100; a2 = 32'h3000; w2 = 32'hCAFEF00D;
        step();
        chk("to_grant", 32'(grant), 32'b100);
        chk("to_swe", 32'(s_we), 32'd1);
        chk("to_swdata", s_wdata, 32'hCAFEF00D);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("to_wait_sreq", 32'(s_req), 32'd1);
            chk("to_wait_err", 32'(m_err), 32'd0);
        end
        step();
        chk("to_err", 32'(m_err), 32'b100);
        chk("to_ack", 32'(m_ack), 32'd0);
        chk("to_sreq", 32'(s_req), 32'd0);
        chk("to_rdata", m_rdata, 32'd0);
        m_req = 3'b000; m_we = 3'b000;
        step();
        chk("to_err_clr", 32'(m_err), 32'd0);

        // Ack on the last allowed BUSY cycle wins over the timeout
        m_req = 3'b010; a1 = 32'h2000;
        step();
        chk("last_grant", 32'(grant), 32'b010);
        for (int i = 1; i < 16; i++) step();
        chk("last_sreq", 32'(s_req), 32'd1);
        s_ack = 1'b1; s_rdata = 32'h55AA55AA;
        step();
        chk("last_ack", 32'(m_ack), 32'b010);
        chk("last_err", 32'(m_err), 32'd0);
        chk("last_rdata", m_rdata, 32'h55AA55AA);
        s_ack = 1'b0; m_req = 3'b000;
        step();

        // m1 drops its request mid-transaction; slave side stays latched
        m_req = 3'b010; a1 = 32'h2468;
        step();
        chk("drop_grant", 32'(grant), 32'b010);
        m_req = 3'b000; a1 = 32'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drop_saddr", s_addr, 32'h2468);
            chk("drop_sreq", 32'(s_req), 32'd1);
        end
        serve("drop", 3'b010, 32'h2468, 32'h77);
        step();

        // Reset in the middle of a transaction
        m_req = 3'b001; a0 = 32'hABC;
        step();
        step();
        chk("mid_busy", 32'(s_req), 32'd1);
        rst_n = 1'b0; m_req = 3'b000; s_ack = 1'b1; s_rdata = 32'h1234;
        step();
        chk("mid_rst_sreq", 32'(s_req), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_ack", 32'(m_ack), 32'd0);
        chk("mid_rst_saddr", s_addr, 32'd0);
        rst_n = 1'b1; s_ack = 1'b0;
        step();
        chk("post_rst_ack", 32'(m_ack), 32'd0);

        // Pointer back at last=2 after reset: m1 beats m2
        m_req = 3'b110; a1 = 32'h5000; a2 = 32'h6000;
        step();
        serve("post_rst", 3'b010, 32'h5000, 32'h600D);
        m_req = 3'b000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
